counters: RTL and testbench

Free-running 3-bit sequence generator selectable at elaboration among six count codes (binary up, binary down, Gray, Johnson, one-hot ring, maximal LFSR). It has no enable and no load, and advances one state per clock. It serves as a standalone timing/pattern source for lab designs and as a reference stimulus generator for downstream blocks.

---
 rtl/counters_pkg.sv | 28 ++
 rtl/counters_next.sv | 41 ++++
 rtl/counters.sv | 48 ++++
 tb/tb_counters.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/counters_pkg.sv
// Shared constants for the counters sequence generator: mode encodings,
// reset values and illegal-state recovery targets.
package counters_pkg;

   localparam int BIN_UP   = 0;
   localparam int BIN_DOWN = 1;
   localparam int GRAY     = 2;
   localparam int JOHNSON  = 3;
   localparam int RING     = 4;
   localparam int LFSR     = 5;

   localparam logic [2:0] RST_ZERO = 3'b000;
   localparam logic [2:0] RST_ONE  = 3'b001;

   localparam logic [2:0] JOHNSON_RECOVER = 3'b000;
   localparam logic [2:0] RING_RECOVER    = 3'b001;
   localparam logic [2:0] LFSR_RECOVER    = 3'b001;

   // RING and LFSR cannot start from zero, so they leave reset at 001
   function automatic logic [2:0] reset_value(input int mode);
      return (mode == RING || mode == LFSR) ? RST_ONE : RST_ZERO;
   endfunction

   function automatic logic [2:0] to_gray(input logic [2:0] b);
      return b ^ (b >> 1);
   endfunction

endpackage

// File: rtl/counters_next.sv
// Combinational next-state map for every counting mode, including the
// recovery of states that are unreachable in normal operation.
module counters_next
   import counters_pkg::*;
#(
   parameter int MODE = BIN_UP
) (
   input  logic [2:0] state,
   output logic [2:0] next
);

   always_comb begin
      next = state;
      case (MODE)
         BIN_UP:   next = state + 3'd1;
         BIN_DOWN: next = state - 3'd1;
         GRAY:     next = state + 3'd1;
         JOHNSON: begin
            if (state == 3'b010 || state == 3'b101)
               next = JOHNSON_RECOVER;
            else
               next = {state[1:0], ~state[2]};
         end
         RING: begin
            if (state == 3'b001 || state == 3'b010 || state == 3'b100)
               next = {state[1:0], state[2]};
            else
               next = RING_RECOVER;
         end
         LFSR: begin
            // x^3+x^2+1 Fibonacci form; the all-zero lockup state is escaped
            if (state == 3'b000)
               next = LFSR_RECOVER;
            else
               next = {state[1:0], state[2] ^ state[1]};
         end
         default: next = state;
      endcase
   end

endmodule

// File: rtl/counters.sv
// Free-running 3-bit pattern source; MODE picks the count code at elaboration.
// Holds the state registers, async reset and the MODE legality check.
module counters
   import counters_pkg::*;
#(
   parameter int MODE = BIN_UP
) (
   input  logic       clk,
   input  logic       rst,
   output logic [2:0] cnt
);

   if (MODE < BIN_UP || MODE > LFSR) begin : g_bad_mode
      $error("counters: MODE %0d is not a legal sequence select", MODE);
   end

   logic [2:0] state_q;
   logic [2:0] state_d;

   counters_next #(.MODE(MODE)) u_next (
      .state (state_q),
      .next  (state_d)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_q <= reset_value(MODE);
      else
         state_q <= state_d;
   end

   // In GRAY mode state_q is the hidden binary count and cnt is its registered Gray image
   if (MODE == GRAY) begin : g_gray
      logic [2:0] gray_q;

      always_ff @(posedge clk or posedge rst) begin
         if (rst)
            gray_q <= RST_ZERO;
         else
            gray_q <= to_gray(state_d);
      end

      assign cnt = gray_q;
   end else begin : g_direct
      assign cnt = state_q;
   end

endmodule

// File: tb/tb_counters.sv
// Self-checking bench for counters: one instance per MODE on a shared clock
// and reset, driven by a table of expected sequences plus corner-case sequences.
module tb_counters;

   logic       clk;
   logic       rst;
   logic [2:0] cnt_all [6];

   int checks = 0;
   int errors = 0;

   for (genvar m = 0; m < 6; m++) begin : g_dut
      counters #(.MODE(m)) dut (
         .clk (clk),
         .rst (rst),
         .cnt (cnt_all[m])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, required finish before 100000 ns");
      $fatal(1, "[TB] watchdog expired");
   end

   typedef struct {
      int mode;
      int len;
      int seq [10];
   } vec_t;

   vec_t vecs [6];

   function automatic logic [2:0] rst_exp(input int m);
      return (m >= 4) ? 3'b001 : 3'b000;
   endfunction

   task automatic check_output(input string name, input logic [2:0] act, input logic [2:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Assert reset away from clock edges, confirm it acts without a clock, then release at a falling edge
   task automatic apply_stimulus_reset(input int m);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_output($sformatf("async_reset_mode%0d", m), cnt_all[m], rst_exp(m));
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [2:0] prev;

      rst = 1'b1;

      vecs[0].mode = 0; vecs[0].len = 10; vecs[0].seq = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
      vecs[1].mode = 1; vecs[1].len = 9;  vecs[1].seq = '{0, 7, 6, 5, 4, 3, 2, 1, 0, 0};
      vecs[2].mode = 2; vecs[2].len = 9;  vecs[2].seq = '{0, 1, 3, 2, 6, 7, 5, 4, 0, 0};
      vecs[3].mode = 3; vecs[3].len = 7;  vecs[3].seq = '{0, 1, 3, 7, 6, 4, 0, 0, 0, 0};
      vecs[4].mode = 4; vecs[4].len = 4;  vecs[4].seq = '{1, 2, 4, 1, 0, 0, 0, 0, 0, 0};
      vecs[5].mode = 5; vecs[5].len = 8;  vecs[5].seq = '{1, 2, 5, 3, 7, 6, 4, 1, 0, 0};

      for (int v = 0; v < 6; v++) begin
         apply_stimulus_reset(vecs[v].mode);
         check_output($sformatf("seq_mode%0d_step0", vecs[v].mode),
                      cnt_all[vecs[v].mode], 3'(vecs[v].seq[0]));
         prev = cnt_all[vecs[v].mode];
         for (int k = 1; k < vecs[v].len; k++) begin
            @(posedge clk);
            #1;
            check_output($sformatf("seq_mode%0d_step%0d", vecs[v].mode, k),
                         cnt_all[vecs[v].mode], 3'(vecs[v].seq[k]));
            if (vecs[v].mode == 2)
               check_output($sformatf("gray_onebit_step%0d", k),
                            3'($countones(prev ^ cnt_all[2])), 3'd1);
            prev = cnt_all[vecs[v].mode];
         end
      end

      // Mid-count reset in BIN_UP: cnt must drop to 0 before the next edge
      apply_stimulus_reset(0);
      repeat (5) @(posedge clk);
      #1;
      check_output("mid_reset_pre", cnt_all[0], 3'd5);
      #2;
      rst = 1'b1;
      #1;
      check_output("mid_reset_immediate", cnt_all[0], 3'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_output("mid_reset_restart", cnt_all[0], 3'd1);

      // Illegal-state recovery: JOHNSON 010, RING 011, LFSR 000
      @(negedge clk);
      force g_dut[3].dut.state_q = 3'b010;
      force g_dut[4].dut.state_q = 3'b011;
      force g_dut[5].dut.state_q = 3'b000;
      #1;
      release g_dut[3].dut.state_q;
      release g_dut[4].dut.state_q;
      release g_dut[5].dut.state_q;
      @(posedge clk);
      #1;
      check_output("recover_johnson_010", cnt_all[3], 3'b000);
      check_output("recover_ring_011", cnt_all[4], 3'b001);
      check_output("recover_lfsr_000", cnt_all[5], 3'b001);

      // Second set: JOHNSON 101, RING 000 and 111
      @(negedge clk);
      force g_dut[3].dut.state_q = 3'b101;
      force g_dut[4].dut.state_q = 3'b000;
      #1;
      release g_dut[3].dut.state_q;
      release g_dut[4].dut.state_q;
      @(posedge clk);
      #1;
      check_output("recover_johnson_101", cnt_all[3], 3'b000);
      check_output("recover_ring_000", cnt_all[4], 3'b001);
      @(negedge clk);
      force g_dut[4].dut.state_q = 3'b111;
      #1;
      release g_dut[4].dut.state_q;
      @(posedge clk);
      #1;
      check_output("recover_ring_111", cnt_all[4], 3'b001);

      // Reset held across 20 edges in every mode
      @(negedge clk);
      rst = 1'b1;
      repeat (20) begin
         @(posedge clk);
         #1;
         for (int m = 0; m < 6; m++)
            check_output($sformatf("hold_reset_mode%0d", m), cnt_all[m], rst_exp(m));
      end

      // Release lands after this edge has sampled rst high, so the edge must be ignored
      @(posedge clk);
      rst <= 1'b0;
      #1;
      for (int m = 0; m < 6; m++)
         check_output($sformatf("release_edge_mode%0d", m), cnt_all[m], rst_exp(m));
      @(posedge clk);
      #1;
      for (int m = 0; m < 6; m++)
         check_output($sformatf("first_advance_mode%0d", m), cnt_all[m], 3'(vecs[m].seq[1]));

      $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
